i4001_bus_responder: RTL and testbench

//  Read-side counterpart of the switch-driven ROM loader: serves the 2048x16 ROM image to a 4004-style
//  4-bit multiplexed bus as up to 16 i4001 chips (256 bytes each). Tracks the 8-cycle bus sequence
//  A1 A2 A3 M1 M2 X1 X2 X3 and issues one ROM column read per instruction fetch.

---
 rtl/i4001_bus_responder_pkg.sv | 25 ++
 rtl/i4001_bus_responder.sv | 104 ++++++++++
 tb/tb_i4001_bus_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/i4001_bus_responder_pkg.sv
// Shared widths and bus-phase encoding for the i4001 ROM bus responder.
package i4001_bus_responder_pkg;

  localparam int unsigned CHIP_BITS      = 4;
  localparam int unsigned CHIP_ADDR_BITS = 8;
  localparam int unsigned COL_BITS       = 11;
  localparam int unsigned NIBBLE_BITS    = 4;
  localparam int unsigned BYTE_BITS      = 8;
  localparam int unsigned WORD_BITS      = 16;
  localparam int unsigned PHASE_BITS     = 3;

  // A1..X3 encode their own phase number; IDLE sits outside the 0..7 range
  typedef enum logic [3:0] {
    PH_A1   = 4'd0,
    PH_A2   = 4'd1,
    PH_A3   = 4'd2,
    PH_M1   = 4'd3,
    PH_M2   = 4'd4,
    PH_X1   = 4'd5,
    PH_X2   = 4'd6,
    PH_X3   = 4'd7,
    PH_IDLE = 4'd8
  } bus_phase_e;

endpackage

// File: rtl/i4001_bus_responder.sv
// Serves the 2048x16 ROM image onto a 4004-style multiplexed nibble bus as up to
// NUM_CHIPS i4001 parts, one ROM column read per instruction fetch.
module i4001_bus_responder
  import i4001_bus_responder_pkg::*;
#(
  parameter int unsigned NUM_CHIPS = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   run,
  input  logic                   step,
  input  logic                   sync,
  input  logic [NIBBLE_BITS-1:0] d_in,
  output logic [NIBBLE_BITS-1:0] d_out,
  output logic                   d_oe,
  output logic [COL_BITS-1:0]    rom_column_id,
  output logic                   rom_rd,
  input  logic [WORD_BITS-1:0]   rom_data,
  output logic [PHASE_BITS-1:0]  phase,
  output logic                   sync_err
);

  bus_phase_e                state, state_n;
  logic [CHIP_ADDR_BITS-1:0] addr;
  logic [BYTE_BITS-1:0]      word, word_n;
  logic                      sel, sel_n;
  logic                      rd_q;
  logic                      capture;
  logic                      resync;

  assign capture = step && !sync;
  assign resync  = step && sync;

  // Next bus phase, chip select and byte returned from the ROM
  always_comb begin
    state_n = state;
    sel_n   = sel;
    word_n  = word;
    if (rd_q && !resync) begin
      word_n = addr[0] ? rom_data[7:0] : rom_data[15:8];
    end
    if (step) begin
      if (sync) begin
        state_n = PH_A1;
      end else begin
        case (state)
          PH_IDLE, PH_X3: state_n = PH_IDLE;
          default:        state_n = bus_phase_e'(state + 4'd1);
        endcase
      end
      if (capture && state == PH_A3) begin
        sel_n = 32'(d_in) < NUM_CHIPS;
      end
    end
  end

  // Phase tracking, address capture, ROM handshake and registered bus drive
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= PH_IDLE;
      addr          <= '0;
      word          <= '0;
      sel           <= 1'b0;
      rd_q          <= 1'b0;
      rom_rd        <= 1'b0;
      rom_column_id <= '0;
      d_out         <= '0;
      d_oe          <= 1'b0;
      phase         <= '0;
      sync_err      <= 1'b0;
    end else if (!run) begin
      state    <= PH_IDLE;
      rd_q     <= 1'b0;
      rom_rd   <= 1'b0;
      d_out    <= '0;
      d_oe     <= 1'b0;
      phase    <= '0;
      sync_err <= 1'b0;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      word   <= word_n;
      phase  <= (state_n == PH_IDLE) ? 3'd0 : state_n[2:0];
      rd_q   <= rom_rd && !resync;
      rom_rd <= capture && (state == PH_A3) && sel_n;
      if (capture) begin
        case (state)
          PH_A1:   addr[3:0]     <= d_in;
          PH_A2:   addr[7:4]     <= d_in;
          PH_A3:   rom_column_id <= {d_in, addr[7:1]};
          PH_X3:   sync_err      <= 1'b1;
          default: ;
        endcase
      end
      d_oe <= sel_n && (state_n == PH_M1 || state_n == PH_M2);
      case (state_n)
        PH_M1:   d_out <= word_n[7:4];
        PH_M2:   d_out <= word_n[3:0];
        default: d_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_i4001_bus_responder.sv
// Directed bench for i4001_bus_responder: fetch, byte select, resync, reset and run control.
module tb_i4001_bus_responder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        run;
  logic        step;
  logic        sync;
  logic [3:0]  d_in;
  logic [3:0]  d_out, d_out4;
  logic        d_oe, d_oe4;
  logic [10:0] rom_column_id, rom_column_id4;
  logic        rom_rd, rom_rd4;
  logic [15:0] rom_data, rom_data4;
  logic [2:0]  phase, phase4;
  logic        sync_err, sync_err4;

  int checks   = 0;
  int failures = 0;
  int rd_cnt   = 0;
  int rd4_cnt  = 0;
  int oe4_cnt  = 0;

  always #5 CLK = ~CLK;

  i4001_bus_responder u_dut (
    .CLK(CLK), .RESET(RESET), .run(run), .step(step), .sync(sync), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .rom_column_id(rom_column_id), .rom_rd(rom_rd),
    .rom_data(rom_data), .phase(phase), .sync_err(sync_err)
  );

  i4001_bus_responder #(.NUM_CHIPS(4)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .run(run), .step(step), .sync(sync), .d_in(d_in),
    .d_out(d_out4), .d_oe(d_oe4), .rom_column_id(rom_column_id4), .rom_rd(rom_rd4),
    .rom_data(rom_data4), .phase(phase4), .sync_err(sync_err4)
  );

  function automatic logic [15:0] rom_image(input logic [10:0] col);
    case (col)
      11'h11A: rom_image = 16'hABCD;
      11'h000: rom_image = 16'h1234;
      default: rom_image = 16'h5A5A;
    endcase
  endfunction

  // Synchronous ROM: data valid one CLK after the read request
  always @(posedge CLK) begin
    if (rom_rd)  rom_data  <= rom_image(rom_column_id);
    if (rom_rd4) rom_data4 <= rom_image(rom_column_id4);
    if (rom_rd)  rd_cnt  <= rd_cnt + 1;
    if (rom_rd4) rd4_cnt <= rd4_cnt + 1;
    if (d_oe4)   oe4_cnt <= oe4_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle: a single-CLK strobe followed by two quiet CLKs
  task automatic bus_step(input logic s, input logic [3:0] d);
    @(negedge CLK);
    step = 1'b1;
    sync = s;
    d_in = d;
    @(negedge CLK);
    step = 1'b0;
    sync = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  int rd_base;
  logic [3:0] seq4 [7];

  initial begin
    rom_data  = 16'h0;
    rom_data4 = 16'h0;
    RESET = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    sync  = 1'b0;
    d_in  = 4'h0;
    repeat (3) @(negedge CLK);
    check("rst_d_oe", 32'(d_oe), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_col", 32'(rom_column_id), 32'd0);
    check("rst_rom_rd", 32'(rom_rd), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    RESET = 1'b1;
    run   = 1'b1;
    @(negedge CLK);

    // Odd address 0x35 on chip 2
    rd_base = rd_cnt;
    bus_step(1'b1, 4'h0);
    check("f1_a1_phase", 32'(phase), 32'd0);
    bus_step(1'b0, 4'h5);
    bus_step(1'b0, 4'h3);
    check("f1_a3_phase", 32'(phase), 32'd2);
    check("f1_no_early_rd", 32'(rd_cnt - rd_base), 32'd0);
    bus_step(1'b0, 4'h2);
    check("f1_col", 32'(rom_column_id), 32'h11A);
    check("f1_rd_pulses", 32'(rd_cnt - rd_base), 32'd1);
    check("f1_m1_oe", 32'(d_oe), 32'd1);
    check("f1_m1_dout", 32'(d_out), 32'hC);
    bus_step(1'b0, 4'h0);
    check("f1_m2_oe", 32'(d_oe), 32'd1);
    check("f1_m2_dout", 32'(d_out), 32'hD);
    bus_step(1'b0, 4'h0);
    check("f1_x1_oe", 32'(d_oe), 32'd0);
    check("f1_x1_phase", 32'(phase), 32'd5);
    bus_step(1'b0, 4'h0);
    bus_step(1'b0, 4'h0);
    check("f1_x3_phase", 32'(phase), 32'd7);
    check("f1_single_rd", 32'(rd_cnt - rd_base), 32'd1);

    // Back-to-back fetch of even address 0x34, then missing SYNC at X3
    bus_step(1'b1, 4'h0);
    check("b2b_phase", 32'(phase), 32'd0);
    check("b2b_sync_err", 32'(sync_err), 32'd0);
    bus_step(1'b0, 4'h4);
    bus_step(1'b0, 4'h3);
    bus_step(1'b0, 4'h2);
    check("f2_m1_dout", 32'(d_out), 32'hA);
    bus_step(1'b0, 4'h0);
    check("f2_m2_dout", 32'(d_out), 32'hB);
    repeat (3) bus_step(1'b0, 4'h0);
    bus_step(1'b0, 4'h0);
    check("nosync_phase", 32'(phase), 32'd0);
    check("nosync_err", 32'(sync_err), 32'd1);
    check("nosync_oe", 32'(d_oe), 32'd0);
    bus_step(1'b0, 4'h0);
    check("idle_hold_phase", 32'(phase), 32'd0);

    // Chip 7 is outside a 4-chip responder
    seq4[0] = 4'h1; seq4[1] = 4'h2; seq4[2] = 4'h7;
    seq4[3] = 4'h0; seq4[4] = 4'h0; seq4[5] = 4'h0; seq4[6] = 4'h0;
    rd_base = rd4_cnt;
    oe4_cnt = oe4_cnt;
    begin
      int oe_base;
      oe_base = oe4_cnt;
      bus_step(1'b1, 4'h0);
      check("nc4_phase0", 32'(phase4), 32'd0);
      for (int i = 0; i < 7; i++) begin
        bus_step(1'b0, seq4[i]);
        check($sformatf("nc4_phase%0d", i + 1), 32'(phase4), 32'(i + 1));
      end
      check("nc4_no_rd", 32'(rd4_cnt - rd_base), 32'd0);
      check("nc4_no_oe", 32'(oe4_cnt - oe_base), 32'd0);
    end
    bus_step(1'b1, 4'h0);

    // Async reset while driving M1
    bus_step(1'b0, 4'h5);
    bus_step(1'b0, 4'h3);
    bus_step(1'b0, 4'h2);
    check("pre_rst_m1_oe", 32'(d_oe), 32'd1);
    #1 RESET = 1'b0;
    #1;
    check("async_rst_oe", 32'(d_oe), 32'd0);
    check("async_rst_phase", 32'(phase), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // Stale sync_err cleared by run=0 mid-fetch
    bus_step(1'b1, 4'h0);
    repeat (7) bus_step(1'b0, 4'h0);
    bus_step(1'b0, 4'h0);
    bus_step(1'b1, 4'h0);
    bus_step(1'b0, 4'h0);
    check("sticky_err", 32'(sync_err), 32'd1);
    check("pre_run0_phase", 32'(phase), 32'd1);
    run = 1'b0;
    repeat (2) @(negedge CLK);
    check("run0_phase", 32'(phase), 32'd0);
    check("run0_sync_err", 32'(sync_err), 32'd0);
    check("run0_oe", 32'(d_oe), 32'd0);
    run = 1'b1;
    bus_step(1'b0, 4'h0);
    check("run1_waits_idle", 32'(phase), 32'd0);

    // Resync during A2 restarts the fetch at column 0
    bus_step(1'b1, 4'h0);
    bus_step(1'b0, 4'h9);
    check("rs_a2_phase", 32'(phase), 32'd1);
    bus_step(1'b1, 4'h0);
    check("rs_a1_phase", 32'(phase), 32'd0);
    check("rs_sync_err", 32'(sync_err), 32'd0);
    bus_step(1'b0, 4'h0);
    bus_step(1'b0, 4'h0);
    bus_step(1'b0, 4'h0);
    check("rs_col", 32'(rom_column_id), 32'h000);
    check("rs_m1_dout", 32'(d_out), 32'h1);
    bus_step(1'b0, 4'h0);
    check("rs_m2_dout", 32'(d_out), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
